// File: rtl/antifurto_pkg.sv
// Shared encodings and default timing constants for the anti-theft controller.
package antifurto_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED   = 3'd0,
        ST_WAIT_OPEN  = 3'd1,
        ST_WAIT_CLOSE = 3'd2,
        ST_ARMING     = 3'd3,
        ST_ARMED      = 3'd4,
        ST_TRIGGERED  = 3'd5,
        ST_ALARM      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        IV_ARM = 2'b00,
        IV_DRV = 2'b01,
        IV_PAS = 2'b10,
        IV_ALM = 2'b11
    } interval_t;

    localparam int unsigned T_ARM_DEFAULT = 6;
    localparam int unsigned T_DRV_DEFAULT = 8;
    localparam int unsigned T_PAS_DEFAULT = 15;
    localparam int unsigned T_ALM_DEFAULT = 10;

endpackage

// File: rtl/antifurto_timer.sv
// Programmable time-parameter bank plus seconds countdown with load/stop/tick.
module antifurto_timer
    import antifurto_pkg::*;
#(
    parameter int unsigned TW        = 4,
    parameter int unsigned T_ARM_DEF = T_ARM_DEFAULT,
    parameter int unsigned T_DRV_DEF = T_DRV_DEFAULT,
    parameter int unsigned T_PAS_DEF = T_PAS_DEFAULT,
    parameter int unsigned T_ALM_DEF = T_ALM_DEFAULT
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          load,
    input  interval_t     sel,
    input  logic          stop,
    input  logic          wr_en,
    input  interval_t     wr_sel,
    input  logic [TW-1:0] wr_value,
    output logic [TW-1:0] time_left,
    output interval_t     interval,
    output logic          running,
    output logic          expired
);

    logic [TW-1:0] param [4];

    assign expired = tick && running && (time_left == TW'(1));

    // A zero duration would never expire, so it is stored as one second.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            param[IV_ARM] <= TW'(T_ARM_DEF);
            param[IV_DRV] <= TW'(T_DRV_DEF);
            param[IV_PAS] <= TW'(T_PAS_DEF);
            param[IV_ALM] <= TW'(T_ALM_DEF);
        end else if (wr_en) begin
            param[wr_sel] <= (wr_value == '0) ? TW'(1) : wr_value;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            time_left <= '0;
            interval  <= IV_ARM;
            running   <= 1'b0;
        end else if (load) begin
            time_left <= param[sel];
            interval  <= sel;
            running   <= 1'b1;
        end else if (stop) begin
            running   <= 1'b0;
        end else if (tick && running && time_left != '0) begin
            time_left <= time_left - TW'(1);
            if (time_left == TW'(1))
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/antifurto_ctrl.sv
// Anti-theft controller: arming/trigger/alarm FSM driving the countdown timer, siren and LED.
module antifurto_ctrl
    import antifurto_pkg::*;
#(
    parameter int unsigned N_DOORS   = 2,
    parameter int unsigned TW        = 4,
    parameter int unsigned T_ARM_DEF = T_ARM_DEFAULT,
    parameter int unsigned T_DRV_DEF = T_DRV_DEFAULT,
    parameter int unsigned T_PAS_DEF = T_PAS_DEFAULT,
    parameter int unsigned T_ALM_DEF = T_ALM_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               one_hz_enable,
    input  logic               ignition,
    input  logic [N_DOORS-1:0] doors,
    input  logic               reprogram,
    input  logic [1:0]         time_param_sel,
    input  logic [TW-1:0]      time_value,
    output logic [1:0]         interval,
    output logic [TW-1:0]      time_left,
    output logic [2:0]         state,
    output logic               status_led,
    output logic               enable_siren
);

    logic [1:0] rst_sync;
    logic       rst_n;
    state_t     cur_state, next_state;
    logic       tmr_load, tmr_stop, tmr_running, tmr_expired;
    interval_t  tmr_sel, tmr_interval;
    logic       any_door;

    // Assert asynchronously, release two edges after reset rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign any_door = |doors;

    antifurto_timer #(
        .TW        (TW),
        .T_ARM_DEF (T_ARM_DEF),
        .T_DRV_DEF (T_DRV_DEF),
        .T_PAS_DEF (T_PAS_DEF),
        .T_ALM_DEF (T_ALM_DEF)
    ) u_timer (
        .clock     (clock),
        .rst_n     (rst_n),
        .tick      (one_hz_enable),
        .load      (tmr_load),
        .sel       (tmr_sel),
        .stop      (tmr_stop),
        .wr_en     (reprogram),
        .wr_sel    (interval_t'(time_param_sel)),
        .wr_value  (time_value),
        .time_left (time_left),
        .interval  (tmr_interval),
        .running   (tmr_running),
        .expired   (tmr_expired)
    );

    always_comb begin
        next_state = cur_state;
        tmr_load   = 1'b0;
        tmr_stop   = 1'b0;
        tmr_sel    = IV_ARM;
        case (cur_state)
            ST_DISARMED:   next_state = ST_WAIT_OPEN;
            ST_WAIT_OPEN:  if (doors[0]) next_state = ST_WAIT_CLOSE;
            ST_WAIT_CLOSE: if (!any_door) begin
                next_state = ST_ARMING;
                tmr_load   = 1'b1;
                tmr_sel    = IV_ARM;
            end
            ST_ARMING: begin
                if (any_door) begin
                    next_state = ST_WAIT_CLOSE;
                    tmr_stop   = 1'b1;
                end else if (tmr_expired) begin
                    next_state = ST_ARMED;
                end
            end
            ST_ARMED: if (any_door) begin
                next_state = ST_TRIGGERED;
                tmr_load   = 1'b1;
                tmr_sel    = doors[0] ? IV_DRV : IV_PAS;
            end
            ST_TRIGGERED: if (tmr_expired) next_state = ST_ALARM;
            ST_ALARM: begin
                if (any_door) begin
                    tmr_stop = 1'b1;
                end else if (!tmr_running) begin
                    tmr_load = 1'b1;
                    tmr_sel  = IV_ALM;
                end else if (tmr_expired) begin
                    next_state = ST_ARMED;
                end
            end
            default: next_state = ST_DISARMED;
        endcase
        // Ignition overrides every transition and halts any countdown.
        if (ignition) begin
            next_state = ST_DISARMED;
            tmr_load   = 1'b0;
            tmr_stop   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= ST_DISARMED;
            enable_siren <= 1'b0;
            status_led   <= 1'b0;
        end else begin
            cur_state    <= next_state;
            enable_siren <= (next_state == ST_ALARM);
            case (next_state)
                ST_TRIGGERED, ST_ALARM: status_led <= 1'b1;
                ST_ARMED: status_led <= (cur_state == ST_ARMED) ? (status_led ^ one_hz_enable) : 1'b0;
                default:  status_led <= 1'b0;
            endcase
        end
    end

    assign state    = cur_state;
    assign interval = tmr_interval;

endmodule
